// File: rtl/dff_response_checker.sv
// dff_response_checker: passive reference-model checker for a D flip-flop with sync reset/set
module dff_response_checker #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr_stats,
  input  logic             mon_reset,
  input  logic             mon_set,
  input  logic             mon_d,
  input  logic             mon_q,
  output logic             exp_q,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid,
  output logic             halted
);
  typedef enum logic [1:0] {IDLE, PRIME, CHECK, HALT} state_t;
  state_t state_q, state_d;
  logic exp_d, mismatch_d, sticky_d, ffv_d, load, cmp, fail;
  logic [ERR_W-1:0] err_d;
  logic [CNT_W-1:0] chk_d, ffi_d;
  always_comb begin
    load = (state_q == IDLE) ? enable : (state_q != HALT);
    cmp = (state_q == CHECK) && enable && !clr_stats;
    fail = cmp && (mon_q !== exp_q);
    state_d = (state_q == HALT) ? (clr_stats ? IDLE : HALT)
            : !enable ? IDLE
            : (fail && STOP_ON_ERR) ? HALT
            : (state_q == IDLE) ? PRIME : CHECK;
    // reset dominates set, set dominates d
    exp_d = load ? (mon_reset ? 1'b0 : (mon_set ? 1'b1 : mon_d)) : exp_q;
    mismatch_d = fail;
    chk_d = clr_stats ? '0 : (cmp && check_count != '1) ? check_count + CNT_W'(1) : check_count;
    err_d = clr_stats ? '0 : (fail && err_count != '1) ? err_count + ERR_W'(1) : err_count;
    sticky_d = !clr_stats && (err_sticky || fail);
    ffv_d = !clr_stats && (first_fail_valid || fail);
    ffi_d = clr_stats ? '0 : (fail && !first_fail_valid) ? check_count : first_fail_idx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      exp_q <= 1'b0;
      mismatch <= 1'b0;
      err_sticky <= 1'b0;
      err_count <= '0;
      check_count <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      mismatch <= mismatch_d;
      err_sticky <= sticky_d;
      err_count <= err_d;
      check_count <= chk_d;
      first_fail_idx <= ffi_d;
      first_fail_valid <= ffv_d;
    end
  end
  assign halted = (state_q == HALT);
endmodule
